// File: rtl/fetch_line_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_line_ctrl_pkg : frontend constants, fetch FSM states, packet   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fetch_line_ctrl_pkg;

  localparam int XLEN            = 64;
  localparam int LINE_BYTES      = 64;
  localparam int FETCH_MAX_BYTES = 64;
  localparam int FTQ_IDX_W       = 5;
  localparam int SIZE_W          = 7;
  localparam int LINE_OFF_W      = $clog2(LINE_BYTES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    REQ1 = 3'd2,
    WAIT = 3'd3,
    OUT  = 3'd4
  } fetchLineState_t;

  typedef struct packed {
    logic [FTQ_IDX_W-1:0]         ftqIdx;
    logic [XLEN-1:0]              startAddr;
    logic [SIZE_W-1:0]            size;
    logic [FETCH_MAX_BYTES*8-1:0] data;
  } fetchPkt_t;

  // Bytes of the block that fit in the first line: min(size, LINE_BYTES - off).
  function automatic logic [SIZE_W-1:0] clamp_to_line(input logic [LINE_OFF_W-1:0] off,
                                                      input logic [SIZE_W-1:0]     size);
    logic [SIZE_W-1:0] room;
    room = SIZE_W'(LINE_BYTES) - SIZE_W'(off);
    return (size < room) ? size : room;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_line_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_line_ctrl_if : FTQ, icache and predecode channels of the       |
// | fetch line controller; master = controller side. Rev 1.0             |
// +----------------------------------------------------------------------+
interface fetch_line_ctrl_if;
  import fetch_line_ctrl_pkg::*;

  logic                         squash_vld;
  logic                         fetch_req;
  logic                         fetch_rdy;
  logic [FTQ_IDX_W-1:0]         fetch_ftqIdx;
  logic [XLEN-1:0]              fetch_startAddr;
  logic [SIZE_W-1:0]            fetch_size;
  logic                         ic_req;
  logic                         ic_rdy;
  logic [XLEN-1:0]              ic_addr;
  logic                         ic_resp_vld;
  logic [LINE_BYTES*8-1:0]      ic_resp_data;
  logic                         pkt_vld;
  logic                         pkt_rdy;
  logic [FTQ_IDX_W-1:0]         pkt_ftqIdx;
  logic [XLEN-1:0]              pkt_startAddr;
  logic [SIZE_W-1:0]            pkt_size;
  logic [FETCH_MAX_BYTES*8-1:0] pkt_data;

  modport master (
    input  squash_vld, fetch_req, fetch_ftqIdx, fetch_startAddr, fetch_size,
           ic_rdy, ic_resp_vld, ic_resp_data, pkt_rdy,
    output fetch_rdy, ic_req, ic_addr,
           pkt_vld, pkt_ftqIdx, pkt_startAddr, pkt_size, pkt_data
  );

  modport slave (
    output squash_vld, fetch_req, fetch_ftqIdx, fetch_startAddr, fetch_size,
           ic_rdy, ic_resp_vld, ic_resp_data, pkt_rdy,
    input  fetch_rdy, ic_req, ic_addr,
           pkt_vld, pkt_ftqIdx, pkt_startAddr, pkt_size, pkt_data
  );

endinterface
`default_nettype wire

// File: rtl/fetch_align_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_align_shifter : byte-aligns {slot1,slot0} to the block start   |
// | and zeroes bytes past the block size. Rev 1.0                        |
// +----------------------------------------------------------------------+
module fetch_align_shifter
  import fetch_line_ctrl_pkg::*;
(
  input  wire logic [2*LINE_BYTES*8-1:0]  i_lines,
  input  wire logic [LINE_OFF_W-1:0]      i_off,
  input  wire logic [SIZE_W-1:0]          i_size,
  output logic      [FETCH_MAX_BYTES*8-1:0] o_data
);

  logic [2*LINE_BYTES*8-1:0] w_shifted;

  always_comb begin
    w_shifted = i_lines >> {i_off, 3'b000};
    o_data    = w_shifted[FETCH_MAX_BYTES*8-1:0];
    for (int i = 0; i < FETCH_MAX_BYTES; i++) begin
      if (i >= int'(i_size)) o_data[i*8 +: 8] = 8'h00;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_line_ctrl : FTQ block -> icache line requests -> aligned fetch |
// | packet; FETCH_CROSSLINE_EN enables two-line blocks. Rev 1.0          |
// +----------------------------------------------------------------------+
module fetch_line_ctrl
  import fetch_line_ctrl_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         rst,   // asynchronous, active-low
  fetch_line_ctrl_if.master bus
);

  fetchLineState_t              r_state, w_state_nxt;
  logic [FTQ_IDX_W-1:0]         r_ftq_idx;
  logic [XLEN-1:0]              r_start;
  logic [SIZE_W-1:0]            r_size;
  logic [LINE_BYTES*8-1:0]      r_slot0;
  logic [1:0]                   r_req_cnt, r_rsp_cnt, r_drop_cnt;
  logic [1:0]                   w_req_cnt_nxt, w_rsp_cnt_nxt, w_drop_nxt, w_need;
  logic [2:0]                   w_drop_sum;
  logic [LINE_OFF_W-1:0]        w_off;
  logic [XLEN-1:0]              w_line0;
  logic [SIZE_W-1:0]            w_pkt_size;
  logic [2*LINE_BYTES*8-1:0]    w_lines;
  logic [FETCH_MAX_BYTES*8-1:0] w_shift_data;
  logic                         w_accept, w_ic_fire, w_busy, w_rsp_take, w_rsp_drop;
  logic                         w_fetch_rdy, w_ic_req, w_go_req1, w_out;
  fetchPkt_t                    w_pkt;

  assign w_off   = r_start[LINE_OFF_W-1:0];
  assign w_line0 = {r_start[XLEN-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};

`ifdef FETCH_CROSSLINE_EN
  logic [LINE_BYTES*8-1:0] r_slot1;
  logic                    r_cross, w_in_cross;
  logic [XLEN-1:0]         w_line1;

  assign w_in_cross = (8'(bus.fetch_startAddr[LINE_OFF_W-1:0]) + 8'(bus.fetch_size)) > 8'(LINE_BYTES);
  assign w_line1    = w_line0 + XLEN'(LINE_BYTES);
  assign w_go_req1  = r_cross;
  assign w_need     = r_cross ? 2'd2 : 2'd1;
  assign w_lines    = {r_slot1, r_slot0};
  assign w_pkt_size = r_size;
  assign bus.ic_addr = (r_state == REQ1) ? w_line1 : ((r_state == REQ0) ? w_line0 : '0);
`else
  // Single-line build: the FTQ refetches whatever lies past the line end.
  assign w_go_req1  = 1'b0;
  assign w_need     = 2'd1;
  assign w_lines    = {{(LINE_BYTES*8){1'b0}}, r_slot0};
  assign w_pkt_size = clamp_to_line(w_off, r_size);
  assign bus.ic_addr = (r_state == REQ0) ? w_line0 : '0;
`endif

  assign w_fetch_rdy   = (r_state == IDLE) && (r_drop_cnt == 2'd0) && !bus.squash_vld && rst;
  assign w_ic_req      = (r_state == REQ0) || (r_state == REQ1);
  assign w_out         = (r_state == OUT);
  assign w_accept      = bus.fetch_req && w_fetch_rdy;
  assign w_ic_fire     = w_ic_req && bus.ic_rdy;
  assign w_busy        = w_ic_req || (r_state == WAIT);
  assign w_rsp_take    = bus.ic_resp_vld && w_busy && (r_drop_cnt == 2'd0);
  assign w_rsp_drop    = bus.ic_resp_vld && (r_drop_cnt != 2'd0);
  assign w_req_cnt_nxt = r_req_cnt + {1'b0, w_ic_fire};
  assign w_rsp_cnt_nxt = r_rsp_cnt + {1'b0, w_rsp_take};
  // Lines still owed by the icache for the abandoned block join the drain count.
  assign w_drop_sum    = {1'b0, r_drop_cnt} + {1'b0, w_req_cnt_nxt - w_rsp_cnt_nxt} - {2'b00, w_rsp_drop};

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop_cnt - {1'b0, w_rsp_drop};
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = REQ0;
      REQ0: if (bus.ic_rdy) w_state_nxt = w_go_req1 ? REQ1 : WAIT;
`ifdef FETCH_CROSSLINE_EN
      REQ1: if (bus.ic_rdy) w_state_nxt = WAIT;
`endif
      WAIT: if (w_rsp_cnt_nxt == w_need) w_state_nxt = OUT;
      OUT:  if (bus.pkt_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (bus.squash_vld) begin
      w_state_nxt = IDLE;
      w_drop_nxt  = (w_drop_sum > 3'd2) ? 2'd2 : w_drop_sum[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ftq_idx  <= '0;
      r_start    <= '0;
      r_size     <= '0;
      r_slot0    <= '0;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_drop_cnt <= '0;
`ifdef FETCH_CROSSLINE_EN
      r_slot1    <= '0;
      r_cross    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_drop_cnt <= w_drop_nxt;
      if (w_accept) begin
        r_ftq_idx <= bus.fetch_ftqIdx;
        r_start   <= bus.fetch_startAddr;
        r_size    <= bus.fetch_size;
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
`ifdef FETCH_CROSSLINE_EN
        r_cross   <= w_in_cross;
`endif
      end else if (bus.squash_vld) begin
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
      end else begin
        r_req_cnt <= w_req_cnt_nxt;
        r_rsp_cnt <= w_rsp_cnt_nxt;
      end
      if (w_rsp_take) begin
`ifdef FETCH_CROSSLINE_EN
        if (r_rsp_cnt == 2'd0) r_slot0 <= bus.ic_resp_data;
        else                   r_slot1 <= bus.ic_resp_data;
`else
        r_slot0 <= bus.ic_resp_data;
`endif
      end
    end
  end

  fetch_align_shifter u_shift (
    .i_lines (w_lines),
    .i_off   (w_off),
    .i_size  (w_pkt_size),
    .o_data  (w_shift_data)
  );

  assign w_pkt.ftqIdx    = r_ftq_idx;
  assign w_pkt.startAddr = r_start;
  assign w_pkt.size      = w_pkt_size;
  assign w_pkt.data      = w_shift_data;

  assign bus.fetch_rdy     = w_fetch_rdy;
  assign bus.ic_req        = w_ic_req;
  assign bus.pkt_vld       = w_out;
  assign bus.pkt_ftqIdx    = w_out ? w_pkt.ftqIdx    : '0;
  assign bus.pkt_startAddr = w_out ? w_pkt.startAddr : '0;
  assign bus.pkt_size      = w_out ? w_pkt.size      : '0;
  assign bus.pkt_data      = w_out ? w_pkt.data      : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_accept)
        assert (bus.fetch_size != '0 && bus.fetch_size <= SIZE_W'(FETCH_MAX_BYTES));
      assert (!(r_state == IDLE && r_drop_cnt == 2'd0 && bus.ic_resp_vld));
      if (bus.squash_vld)
        assert (w_drop_sum <= 3'd2);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fetch_line_ctrl : directed self-checking bench for fetch_line_ctrl|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fetch_line_ctrl;
  import fetch_line_ctrl_pkg::*;

`ifdef FETCH_CROSSLINE_EN
  localparam bit XL = 1'b1;
`else
  localparam bit XL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  fetch_line_ctrl_if bus ();

  fetch_line_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Line contents: byte i of the line at base = low byte of (base + i).
  function automatic logic [511:0] line_pat(input logic [63:0] base);
    logic [511:0] d;
    for (int i = 0; i < 64; i++) d[i*8 +: 8] = base[7:0] + 8'(i);
    return d;
  endfunction

  function automatic logic [511:0] exp_data(input logic [63:0] start, input logic [6:0] n);
    logic [511:0] d;
    d = '0;
    for (int j = 0; j < 64; j++) if (j < int'(n)) d[j*8 +: 8] = start[7:0] + 8'(j);
    return d;
  endfunction

  function automatic logic [6:0] eff_size(input logic [63:0] start, input logic [6:0] size);
    int room;
    room = 64 - int'(start[5:0]);
    if (!XL && int'(size) > room) return 7'(room);
    return size;
  endfunction

  function automatic bit is_cross(input logic [63:0] start, input logic [6:0] size);
    return XL && ((int'(start[5:0]) + int'(size)) > 64);
  endfunction

  task automatic do_block(input logic [4:0] idx, input logic [63:0] start, input logic [6:0] size,
                          input int ic_stall, input int pkt_stall, input bit squash_out,
                          input string nm);
    logic [63:0]  line0;
    logic [511:0] pkt;
    int           nlines;
    line0  = {start[63:6], 6'd0};
    nlines = is_cross(start, size) ? 2 : 1;
    pkt    = exp_data(start, eff_size(start, size));
    bus.fetch_req = 1'b1; bus.fetch_ftqIdx = idx; bus.fetch_startAddr = start; bus.fetch_size = size;
    #1 chk({nm, "_accept_rdy"}, bus.fetch_rdy, 1);
    cyc();
    bus.fetch_req = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      for (int s = 0; s < ic_stall; s++) begin
        chk({nm, "_stall_req"}, bus.ic_req, 1);
        chk({nm, "_stall_addr"}, bus.ic_addr, line0 + 64'(l * 64));
        chk({nm, "_stall_rdy"}, bus.fetch_rdy, 0);
        cyc();
      end
      chk({nm, "_ic_req"}, bus.ic_req, 1);
      chk({nm, "_ic_addr"}, bus.ic_addr, line0 + 64'(l * 64));
      bus.ic_rdy = 1'b1;
      cyc();
      bus.ic_rdy = 1'b0;
      if (l == 0 && nlines == 2) begin
        // line0 returns while the second request is still pending
        bus.ic_resp_vld = 1'b1; bus.ic_resp_data = line_pat(line0);
        cyc();
        bus.ic_resp_vld = 1'b0;
      end
    end
    chk({nm, "_wait_noreq"}, bus.ic_req, 0);
    bus.ic_resp_vld = 1'b1; bus.ic_resp_data = line_pat(line0 + 64'((nlines - 1) * 64));
    cyc();
    bus.ic_resp_vld = 1'b0;
    for (int s = 0; s <= pkt_stall; s++) begin
      chk({nm, "_pkt_vld"}, bus.pkt_vld, 1);
      chk({nm, "_pkt_idx"}, bus.pkt_ftqIdx, idx);
      chk({nm, "_pkt_addr"}, bus.pkt_startAddr, start);
      chk({nm, "_pkt_size"}, bus.pkt_size, eff_size(start, size));
      chk({nm, "_pkt_data"}, bus.pkt_data, pkt);
      chk({nm, "_out_rdy"}, bus.fetch_rdy, 0);
      if (s < pkt_stall) cyc();
    end
    if (squash_out) begin
      bus.squash_vld = 1'b1;
      #1 chk({nm, "_sq_rdy"}, bus.fetch_rdy, 0);
    end else begin
      bus.pkt_rdy = 1'b1;
    end
    cyc();
    bus.squash_vld = 1'b0;
    bus.pkt_rdy    = 1'b0;
    #1;
    chk({nm, "_done_vld"}, bus.pkt_vld, 0);
    chk({nm, "_done_rdy"}, bus.fetch_rdy, 1);
  endtask

  initial begin
    int nreq;
    bus.squash_vld = 1'b0; bus.fetch_req = 1'b0; bus.fetch_ftqIdx = '0;
    bus.fetch_startAddr = '0; bus.fetch_size = '0; bus.ic_rdy = 1'b0;
    bus.ic_resp_vld = 1'b0; bus.ic_resp_data = '0; bus.pkt_rdy = 1'b0;
    #2;
    chk("rst_fetch_rdy", bus.fetch_rdy, 0);
    chk("rst_ic_req", bus.ic_req, 0);
    chk("rst_ic_addr", bus.ic_addr, 0);
    chk("rst_pkt_vld", bus.pkt_vld, 0);
    chk("rst_pkt_size", bus.pkt_size, 0);
    chk("rst_pkt_data", bus.pkt_data, 0);
    repeat (2) cyc();
    rst = 1'b1;
    #1 chk("rel_fetch_rdy", bus.fetch_rdy, 1);

    do_block(5'd3,  64'h8000_0010, 7'd32, 0, 0, 1'b0, "noncross");
    do_block(5'd4,  64'h8000_0020, 7'd32, 0, 0, 1'b0, "lineend");
    do_block(5'd5,  64'h8000_0030, 7'd32, 0, 0, 1'b0, "cross");
    do_block(5'd6,  64'h8000_0030, 7'd32, 3, 4, 1'b0, "bp");

    // squash in WAIT with every request outstanding
    nreq = XL ? 2 : 1;
    bus.fetch_req = 1'b1; bus.fetch_ftqIdx = 5'd7; bus.fetch_startAddr = 64'h8000_0030; bus.fetch_size = 7'd32;
    #1 chk("sqw_accept_rdy", bus.fetch_rdy, 1);
    cyc();
    bus.fetch_req = 1'b0;
    bus.ic_rdy = 1'b1;
    cyc();
`ifdef FETCH_CROSSLINE_EN
    cyc();
`endif
    bus.ic_rdy = 1'b0;
    chk("sqw_wait_noreq", bus.ic_req, 0);
    bus.squash_vld = 1'b1;
    #1 chk("sqw_sq_rdy", bus.fetch_rdy, 0);
    cyc();
    bus.squash_vld = 1'b0;
    chk("sqw_idle_vld", bus.pkt_vld, 0);
    for (int r = 0; r < nreq; r++) begin
      chk("sqw_drain_rdy", bus.fetch_rdy, 0);
      bus.ic_resp_vld = 1'b1; bus.ic_resp_data = {512{1'b1}};
      cyc();
      bus.ic_resp_vld = 1'b0;
    end
    #1 chk("sqw_drained_rdy", bus.fetch_rdy, 1);
    do_block(5'd9,  64'h8000_1008, 7'd64, 0, 1, 1'b0, "postsq");

    do_block(5'd10, 64'h8000_0000, 7'd1,  0, 0, 1'b1, "sqout");

    // reset while a line request is pending
    bus.fetch_req = 1'b1; bus.fetch_ftqIdx = 5'd11; bus.fetch_startAddr = 64'h8000_0030; bus.fetch_size = 7'd32;
    #1;
    cyc();
    bus.fetch_req = 1'b0;
`ifdef FETCH_CROSSLINE_EN
    bus.ic_rdy = 1'b1;
    cyc();
    bus.ic_rdy = 1'b0;
`endif
    chk("rm_pre_req", bus.ic_req, 1);
    chk("rm_pre_addr", bus.ic_addr, XL ? 64'h8000_0040 : 64'h8000_0000);
    rst = 1'b0;
    #1;
    chk("rm_ic_req", bus.ic_req, 0);
    chk("rm_ic_addr", bus.ic_addr, 0);
    chk("rm_fetch_rdy", bus.fetch_rdy, 0);
    chk("rm_pkt_vld", bus.pkt_vld, 0);
    cyc();
    cyc();
    rst = 1'b1;
    #1 chk("rm_rel_rdy", bus.fetch_rdy, 1);

    do_block(5'd12, 64'hFFFF_FFFF_FFFF_FFF0, 7'd32, 0, 0, 1'b0, "wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_line_ctrl.md
Name: fetch_line_ctrl

Overview:
- Sits directly downstream of the FTQ fetch port and upstream of the icache and predecode.
- Accepts one fetch block per handshake (ftqIdx, startAddr, fetchBlock_size) and issues one or two 64B icache line requests; two are needed when the block crosses a line.
- Collects the in-order line responses and shifts them into a byte-aligned fetch packet for predecode.
- On squash, abandons in-flight work and drains stale icache responses.

Parameters:
- XLEN, 64, address width.
- LINE_BYTES, 64, icache line size (power of 2).
- FETCH_MAX_BYTES, 64, maximum fetch block size.
- FTQ_IDX_W, 5, FTQ index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_squash_vld  in  1  flush all in-flight state.
- i_fetch_req  in  1  FTQ block valid.
- o_fetch_rdy  out  1  block accepted when req&rdy.
- i_fetch_ftqIdx  in  FTQ_IDX_W  block FTQ index.
- i_fetch_startAddr  in  XLEN  block start byte address.
- i_fetch_size  in  7  block byte count, 1..FETCH_MAX_BYTES.
- o_ic_req  out  1  icache line request valid.
- i_ic_rdy  in  1  icache accepts request.
- o_ic_addr  out  XLEN  line-aligned address (low log2(LINE_BYTES) bits zero).
- i_ic_resp_vld  in  1  line data valid; responses return in request order.
- i_ic_resp_data  in  LINE_BYTES*8  line data.
- o_pkt_vld  out  1  fetch packet valid.
- i_pkt_rdy  in  1  predecode accepts packet.
- o_pkt_ftqIdx  out  FTQ_IDX_W  packet FTQ index.
- o_pkt_startAddr  out  XLEN  packet start address.
- o_pkt_size  out  7  valid byte count.
- o_pkt_data  out  FETCH_MAX_BYTES*8  byte 0 = byte at startAddr.

Behaviour:
- Reset values: all outputs 0; state IDLE; drop_cnt 0.
- Offset: off = startAddr[log2(LINE_BYTES)-1:0]; cross = (off + size) > LINE_BYTES, computed at 8-bit width.
- Line addresses: line0 = startAddr with offset bits cleared; line1 = line0 + LINE_BYTES, wrap modulo 2^XLEN.
- States and transitions:
  - IDLE: o_fetch_rdy=1; on accept, latch block, go REQ0.
  - REQ0: o_ic_req=1 with line0; on i_ic_rdy go REQ1 if cross, else WAIT.
  - REQ1: o_ic_req=1 with line1; on i_ic_rdy go WAIT.
  - WAIT: store responses into slot0, then slot1; when all expected lines have returned, go OUT.
    - A response may arrive in the same cycle the request is accepted plus one or more later cycles.
    - Responses arriving during REQ1 are stored into slot0.
  - OUT: o_pkt_vld=1; o_pkt_data = ({slot1,slot0} >> off*8) truncated to FETCH_MAX_BYTES*8; bytes at index >= size are 0.
    - On i_pkt_rdy return to IDLE.
    - No same-cycle re-accept; o_fetch_rdy=1 only in IDLE.
- Latency: the packet is valid at the earliest one cycle after the final response.
- Squash, highest priority, any state:
  - Next state IDLE; o_pkt_vld drops next cycle.
  - drop_cnt += (requests issued) - (responses received) for the current block.
  - o_fetch_rdy forced 0 in the squash cycle.
- Drain: while drop_cnt != 0, each i_ic_resp_vld decrements drop_cnt and is discarded.
  - o_fetch_rdy stays 0 until drop_cnt == 0.
  - drop_cnt is 2 bits and saturates at 2 (assert never exceeds).
- Assertions:
  - i_fetch_size in 1..FETCH_MAX_BYTES on accept.
  - No i_ic_resp_vld in IDLE when drop_cnt == 0.

Optional Feature:
- Macro: FETCH_CROSSLINE_EN.
- Defined: behaviour as above; two-line requests for crossing blocks.
- Undefined:
  - Never issue line1.
  - o_pkt_size = min(size, LINE_BYTES - off).
  - REQ1 state and slot1 are removed; the FTQ refetches the remainder after redirect.

Decomposition:
- Shared frontend package:
  - LINE_BYTES and FETCH_MAX_BYTES constants.
  - fetchLineState_t enum {IDLE, REQ0, REQ1, WAIT, OUT}.
  - fetchPkt_t struct (ftqIdx, startAddr, size, data).
- Sub-module fetch_align_shifter: combinational byte shifter plus tail mask, {slot1,slot0}, off, size -> data.

Test Plan:
- Non-crossing: startAddr=0x8000_0010, size=32, line data bytes=index -> one request to 0x8000_0000; packet bytes 0x10..0x2F; ftqIdx echoed.
- Crossing: startAddr=0x8000_0030, size=32 -> requests 0x8000_0000 then 0x8000_0040; packet = line0 bytes 0x30..0x3F followed by line1 bytes 0..15.
- Backpressure: i_ic_rdy low for 3 cycles, then i_pkt_rdy low for 4 cycles -> o_ic_addr and packet held stable; o_fetch_rdy=0 throughout.
- Squash in WAIT after 2 requests and 0 responses -> drop_cnt=2; next 2 responses discarded; o_fetch_rdy=1 only after the second response; the following block is fetched correctly.
- Squash in OUT -> o_pkt_vld=0 next cycle; drop_cnt=0; o_fetch_rdy=1 one cycle later.
- Reset asserted mid-REQ1 -> all outputs 0 immediately and asynchronously; state IDLE after release.
- With FETCH_CROSSLINE_EN undefined, crossing case -> one request; o_pkt_size=16.
